// File: rtl/mcpu_mem_pkg.sv
// Shared types and constants for the multicycle CPU memory port.
package mcpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module rr_arb2
  import mcpu_mem_pkg::*;
(
  input  logic req_if,
  input  logic req_d,
  input  logic last,
  output logic grant_valid_c,
  output logic grant_id_c
);

  always_comb begin
    grant_valid_c = req_if | req_d;
    grant_id_c    = REQ_IF;
    if (req_if && req_d) begin
      grant_id_c = (last == REQ_IF) ? REQ_D : REQ_IF;
    end else if (req_d) begin
      grant_id_c = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch and load/store,
// holding each access for WAIT_CYCLES extra cycles and returning a one-cycle ack.
module mem_port_arbiter
  import mcpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_r,
  output logic              mem_w,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             gnt_id;
  logic             gnt_we;
  logic             last_gnt;

  logic             grant_valid_c;
  logic             grant_id_c;
  logic             grant_c;
  logic             last_beat_c;
  logic             read_c;

  logic             mem_r_nxt;
  logic             mem_w_nxt;
  logic             busy_nxt;
  logic             if_ack_nxt;
  logic             d_ack_nxt;

  rr_arb2 u_arb (
    .req_if        (if_req),
    .req_d         (d_req),
    .last          (last_gnt),
    .grant_valid_c (grant_valid_c),
    .grant_id_c    (grant_id_c)
  );

  assign grant_c     = (state == IDLE) && grant_valid_c;
  assign last_beat_c = (state == ACCESS) && (cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid_c) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered strobes/acks, derived from the upcoming state
  always_comb begin
    read_c     = 1'b0;
    mem_r_nxt  = 1'b0;
    mem_w_nxt  = 1'b0;
    busy_nxt   = 1'b0;
    if_ack_nxt = 1'b0;
    d_ack_nxt  = 1'b0;
    if (state == IDLE) begin
      read_c = (grant_id_c == REQ_IF) || !d_we;
    end else begin
      read_c = !gnt_we;
    end
    busy_nxt = (state_nxt != IDLE);
    if (state_nxt == ACCESS) begin
      mem_r_nxt = read_c;
      mem_w_nxt = !read_c;
    end
    if (state_nxt == DONE) begin
      if_ack_nxt = (gnt_id == REQ_IF);
      d_ack_nxt  = (gnt_id == REQ_D);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r  <= 1'b0;
      mem_w  <= 1'b0;
      busy   <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
    end else begin
      mem_r  <= mem_r_nxt;
      mem_w  <= mem_w_nxt;
      busy   <= busy_nxt;
      if_ack <= if_ack_nxt;
      d_ack  <= d_ack_nxt;
    end
  end

  // Grant latching, wait counter, read-data capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      gnt_id   <= REQ_IF;
      gnt_we   <= 1'b0;
      last_gnt <= REQ_IF;
      mem_addr <= '0;
      mem_wd   <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (grant_c) begin
        gnt_id   <= grant_id_c;
        gnt_we   <= (grant_id_c == REQ_D) && d_we;
        mem_addr <= (grant_id_c == REQ_D) ? d_addr : if_addr;
        mem_wd   <= d_wdata;
        cnt      <= CNT_W'(WAIT_CYCLES);
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (last_beat_c) begin
        last_gnt <= gnt_id;
        if (!gnt_we) begin
          if (gnt_id == REQ_IF) begin
            if_rdata <= mem_rd;
          end else begin
            d_rdata <= mem_rd;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle-timed checks plus an ack scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned W  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_r;
  logic          mem_w;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_r    (mem_r),
    .mem_w    (mem_w),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .busy     (busy)
  );

  function automatic logic [DW-1:0] golden_word(input logic [4:0] idx);
    case (idx)
      5'd3:    return 32'h0022_1820;
      5'd8:    return 32'h8D04_000A;
      5'd9:    return 32'h03E0_0008;
      default: return 32'h0;
    endcase
  endfunction

  // 32-word memory, combinational read, reloaded while reset is held
  logic [DW-1:0] mem [32];
  assign mem_rd = mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= golden_word(5'(i));
    end else if (mem_w) begin
      mem[mem_addr[6:2]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          is_d;
    logic [DW-1:0] if_rd;
    logic [DW-1:0] d_rd;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] m_if_rd;
  logic [DW-1:0] m_d_rd;
  logic          strobe_q;
  logic [AW-1:0] addr_q;

  task automatic expect_ack(input logic is_d, input logic we, input logic [AW-1:0] addr);
    if (!we) begin
      if (is_d) m_d_rd = golden_word(addr[6:2]);
      else      m_if_rd = golden_word(addr[6:2]);
    end
    sb.push_back('{is_d, m_if_rd, m_d_rd});
  endtask

  // Ack scoreboard, strobe exclusivity and address stability during ACCESS
  always @(negedge clk) begin
    if (rst) begin
      strobe_q = 1'b0;
    end else begin
      if (if_ack || d_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 64'({if_ack, d_ack}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("ack_who", 64'({if_ack, d_ack}), mon_e.is_d ? 64'd1 : 64'd2);
          check("if_rdata", 64'(if_rdata), 64'(mon_e.if_rd));
          check("d_rdata", 64'(d_rdata), 64'(mon_e.d_rd));
        end
      end
      if (mem_r || mem_w) begin
        check("one_strobe", 64'(mem_r ^ mem_w), 64'd1);
        if (strobe_q) check("addr_stable", 64'(mem_addr), 64'(addr_q));
      end
      strobe_q = mem_r | mem_w;
      addr_q   = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'({mem_r, mem_w}), 64'd0);
    check("rst_acks", 64'({if_ack, d_ack}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wd", 64'(mem_wd), 64'd0);
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);
    rst = 1'b0;
    m_if_rd = '0;
    m_d_rd  = '0;
    sb.delete();
  endtask

  // One uncontended access; caller is positioned in an IDLE cycle (cycle 0)
  task automatic run_single(input logic is_d, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
    logic in_acc;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    expect_ack(is_d, we, addr);
    for (int c = 1; c <= int'(W) + 3; c++) begin
      tick();
      in_acc = (c <= int'(W) + 1);
      check("mem_r", 64'(mem_r), 64'(in_acc && !we));
      check("mem_w", 64'(mem_w), 64'(in_acc && we));
      check("busy", 64'(busy), 64'(c <= int'(W) + 2));
      check("own_ack", is_d ? 64'(d_ack) : 64'(if_ack), 64'(c == int'(W) + 2));
      check("other_ack", is_d ? 64'(if_ack) : 64'(d_ack), 64'd0);
      if (in_acc) begin
        check("mem_addr", 64'(mem_addr), 64'(addr));
        if (we) check("mem_wd", 64'(mem_wd), 64'(wd));
      end
      if (c == int'(W) + 2) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
  endtask

  int n_acks;
  int prev_ack;

  initial begin
    reset_dut();

    // Single fetch, store, load then fetch
    run_single(1'b0, 1'b0, 32'h0000_000C, '0);
    run_single(1'b1, 1'b1, 32'h0000_0012, 32'h0000_000C);
    check("store_mem", 64'(mem[4]), 64'h0000_000C);
    run_single(1'b1, 1'b0, 32'h0000_0020, '0);
    run_single(1'b0, 1'b0, 32'h0000_0024, '0);

    // Both held high from reset: D, F, D, F, one period apart
    reset_dut();
    if_addr = 32'h0000_000C; d_addr = 32'h0000_0020; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    expect_ack(1'b1, 1'b0, d_addr);
    expect_ack(1'b0, 1'b0, if_addr);
    expect_ack(1'b1, 1'b0, d_addr);
    expect_ack(1'b0, 1'b0, if_addr);
    n_acks = 0;
    prev_ack = 0;
    for (int c = 1; c <= 4 * (int'(W) + 3) + 8 && n_acks < 4; c++) begin
      tick();
      if (if_ack || d_ack) begin
        if (n_acks == 0) check("rr_first_ack", 64'(c), 64'(int'(W) + 2));
        else             check("rr_period", 64'(c - prev_ack), 64'(int'(W) + 3));
        prev_ack = c;
        n_acks++;
        if (n_acks == 4) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    check("rr_ack_count", 64'(n_acks), 64'd4);
    tick();
    check("rr_sb_empty", 64'(sb.size()), 64'd0);

    // Data request arriving during a fetch's ACCESS waits for the next IDLE
    reset_dut();
    if_req = 1'b1; if_addr = 32'h0000_0024;
    expect_ack(1'b0, 1'b0, if_addr);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    expect_ack(1'b1, 1'b0, d_addr);
    for (int c = 2; c <= 2 * int'(W) + 5; c++) begin
      tick();
      check("late_if_ack", 64'(if_ack), 64'(c == int'(W) + 2));
      check("late_d_ack", 64'(d_ack), 64'(c == 2 * int'(W) + 5));
      if (c == int'(W) + 2) if_req = 1'b0;
      if (c == int'(W) + 3) check("late_idle", 64'(busy), 64'd0);
      if (c == int'(W) + 4) begin
        check("late_grant_r", 64'(mem_r), 64'd1);
        check("late_grant_addr", 64'(mem_addr), 64'h20);
      end
      if (c == 2 * int'(W) + 5) d_req = 1'b0;
    end
    tick();

    // Reset in the second ACCESS cycle of a store aborts it without ack
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0030; d_wdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("abort_pre_w", 64'(mem_w), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    m_if_rd = '0; m_d_rd = '0;
    check("abort_mem_w", 64'(mem_w), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_acks", 64'({if_ack, d_ack}), 64'd0);
    check("abort_outs", 64'({mem_addr, mem_wd} == '0), 64'd1);
    for (int c = 0; c < 2 * (int'(W) + 3); c++) begin
      tick();
      check("abort_no_ack", 64'({if_ack, d_ack, busy}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single instruction/data memory port of the multicycle CPU between the fetch unit and the load/store unit. It arbitrates between the two requesters with a two-way round robin and drives the memory's address, read strobe, write strobe and write data for a programmable number of wait cycles. It registers the read data and returns a one-cycle acknowledge to the granted requester. It sits between the CPU control FSM and the 32-word word-addressed memory, which decodes `addr[6:2]` and has a combinational read.

## Interface
- `ADDR_W`, 32, address width, passed through unmodified.
- `DATA_W`, 32, data word width.
- `WAIT_CYCLES`, 0, extra memory cycles per access; legal range 0–15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request (read only).
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_ack`  out  1  one-cycle pulse; fetch completed.
- `if_rdata`  out  DATA_W  fetched instruction; valid while `if_ack` is high, held afterwards.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  DATA_W  store data.
- `d_ack`  out  1  one-cycle pulse; data access completed.
- `d_rdata`  out  DATA_W  load data; valid while `d_ack` is high, held afterwards.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_r`  out  1  memory read strobe.
- `mem_w`  out  1  memory write strobe.
- `mem_wd`  out  DATA_W  memory write data.
- `mem_rd`  in  DATA_W  memory read data (combinational from `mem_addr`).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester that was not granted last (round robin).
  - On grant, latch the requester id and the address, `d_we` and `d_wdata` into internal registers. Load the wait counter with `WAIT_CYCLES`. Go to ACCESS.
- ACCESS:
  - `mem_addr` and `mem_wd` come from the latched registers.
  - `mem_r` = 1 for a fetch or a load; `mem_w` = 1 for a store. Exactly one strobe is high during every ACCESS cycle.
  - Counter ≠ 0: decrement and stay in ACCESS.
  - Counter = 0: capture `mem_rd` into the granted requester's rdata register (reads only). Update the last-grant pointer. Go to DONE.
- DONE:
  - Assert the granted requester's ack for exactly this cycle. Go to IDLE.
- Stores leave `d_rdata` unchanged.
- The non-granted rdata register is never modified.
- Outside ACCESS: `mem_r` = `mem_w` = 0. `mem_addr` and `mem_wd` hold their last values (no X).
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Requester rules:
  - Hold `req`, address and data stable until ack.
  - Requests are never cancelled; a dropped `req` before ack is a protocol violation, and the access still completes.
  - After ack, the requester may keep `req` high with new fields; that counts as a fresh request in the following IDLE cycle.

## Timing
- Reset values:
  - State IDLE; wait counter 0.
  - Last-grant pointer = fetch, so data wins the first tie.
  - All outputs 0: `if_ack`, `d_ack`, `mem_r`, `mem_w`, `busy`, `mem_addr`, `mem_wd`, `if_rdata`, `d_rdata`.
- Latency, with the request sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1 .. 1+WAIT_CYCLES.
  - Ack is high in cycle 2+WAIT_CYCLES.
  - Back-to-back service period: WAIT_CYCLES+3 cycles.
- Both requesters held high continuously: grants strictly alternate D, F, D, F, …
- A request arriving during ACCESS or DONE waits; it is sampled in the next IDLE cycle.
- Reset mid-ACCESS:
  - Abort; next cycle is IDLE with all outputs at reset values.
  - No ack is issued for the aborted access.
  - A store may have partially occurred; this is accepted.
- Reset wins over every simultaneous event.
- `busy` = 1 in ACCESS and DONE.

## Structure
- Package `mcpu_mem_pkg`:
  - state enum {IDLE, ACCESS, DONE}
  - requester id constants REQ_IF = 0, REQ_D = 1
  - default ADDR_W and DATA_W constants
- Sub-module `rr_arb2`, a combinational two-way round-robin picker:
  - inputs: the two request bits and the last-grant bit
  - outputs: grant valid and grant id

## Test plan
- Reset, then `if_req` = 1, `if_addr` = 0x0000000C, `mem_rd` = 0x00221820, WAIT_CYCLES = 0 → `mem_r` = 1 in cycle 1 only; `if_ack` = 1 in cycle 2; `if_rdata` = 0x00221820; `d_ack` stays 0.
- `d_req` = 1, `d_we` = 1, `d_addr` = 0x12, `d_wdata` = 0xC, WAIT_CYCLES = 2 → `mem_w` = 1 for cycles 1–3 with `mem_addr` = 0x12 and `mem_wd` = 0xC; `d_ack` in cycle 4; `d_rdata` unchanged (0).
- `if_req` and `d_req` raised in the same cycle after reset, both held high → acks in order d, if, d, if, each WAIT_CYCLES+3 apart.
- Load completes with `mem_rd` = 0x8D04000A, then a fetch completes with `mem_rd` = 0x03E00008 → `d_rdata` stays 0x8D04000A; `if_rdata` = 0x03E00008.
- `rst` asserted in the second ACCESS cycle of a store (WAIT_CYCLES = 3) → next cycle IDLE; `mem_w`, `busy` and both acks are 0; no ack is ever issued for that access.
- `d_req` rises during an in-flight fetch's ACCESS → `d_req` is granted in the IDLE cycle right after the fetch ack; `mem_addr` never changes during any ACCESS.
